// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped programmable down-counter timer with IRQ
// Optional CTRL[4+:PSC_W] prescaler is built when TIMER_PRESCALE_EN is defined.
module timer_counter #(
  parameter int COUNT_W = 32,
  parameter int PSC_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic [1:0]         mode_q, mode_d;
  logic               im_q, im_d;
  logic               pend_q, pend_d;
  logic [COUNT_W-1:0] preset_q, preset_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               tick;
  logic               reg_wr;
  logic [31:0]        ctrl_rd;
  logic               unused_ok;

  assign unused_ok = ^{addr[31:4], 1'(PSC_W)};
  assign reg_wr    = we && (addr[3:2] == 2'd0 || addr[3:2] == 2'd1);

`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] pcnt_q, pcnt_d;
  assign tick    = (pcnt_q == psc_q);
  assign ctrl_rd = 32'({psc_q, im_q, mode_q, en_q});
`else
  assign tick    = 1'b1;
  assign ctrl_rd = {28'd0, im_q, mode_q, en_q};
`endif

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    pend_d   = pend_q;
    preset_d = preset_q;
    count_d  = count_q;
`ifdef TIMER_PRESCALE_EN
    psc_d    = psc_q;
    pcnt_d   = pcnt_q;
`endif
    // A register write pre-empts whatever the FSM would do on this edge.
    if (reg_wr) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
`ifdef TIMER_PRESCALE_EN
      pcnt_d  = '0;
`endif
      if (addr[3:2] == 2'd0) begin
        en_d   = din[0];
        mode_d = din[2:1];
        im_d   = din[3];
`ifdef TIMER_PRESCALE_EN
        psc_d  = din[4 +: PSC_W];
`endif
      end else begin
        preset_d = din[COUNT_W-1:0];
      end
    end else begin
      case (state_q)
        S_IDLE: if (en_q) state_d = S_LOAD;
        S_LOAD: begin
          count_d = preset_q;
          state_d = S_CNT;
`ifdef TIMER_PRESCALE_EN
          pcnt_d  = '0;
`endif
        end
        S_CNT: begin
          if (!en_q) begin
            state_d = S_IDLE;
          end else if (tick) begin
            if (count_q > COUNT_W'(1)) begin
              count_d = count_q - COUNT_W'(1);
            end else begin
              count_d = '0;
              pend_d  = 1'b1;
              state_d = S_INT;
            end
          end
`ifdef TIMER_PRESCALE_EN
          if (en_q) pcnt_d = tick ? '0 : pcnt_q + PSC_W'(1);
`endif
        end
        S_INT: begin
          state_d = S_IDLE;
          if (mode_q == 2'b00) en_d = 1'b0;
          else                 pend_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
`ifdef TIMER_PRESCALE_EN
      psc_q    <= '0;
      pcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
      preset_q <= preset_d;
      count_q  <= count_d;
`ifdef TIMER_PRESCALE_EN
      psc_q    <= psc_d;
      pcnt_q   <= pcnt_d;
`endif
    end
  end

  always_comb begin
    dout = '0;
    case (addr[3:2])
      2'd0:    dout = ctrl_rd;
      2'd1:    dout = 32'(preset_q);
      2'd2:    dout = 32'(count_q);
      default: dout = '0;
    endcase
  end

  assign irq = pend_q & im_q;

endmodule
